// File: rtl/id_inst_buffer_pkg.sv
// Shared constants and helpers for the ID-stage instruction buffer.
// Entry layout is {pc, inst}, matching the IF-to-ID bundle width.
package id_inst_buffer_pkg;

    localparam int ID_BUF_DEPTH = 4;
    localparam int ID_PC_W      = 32;
    localparam int ID_INST_W    = 32;
    localparam int IF_TO_ID_WD  = ID_PC_W + ID_INST_W;

    // How this cycle's flush request reshapes the queue.
    typedef enum logic [2:0] {
        FL_NONE,
        FL_ALL,
        FL_KEEP_HEAD,
        FL_KEEP_ENQ,
        FL_KEEP_NONE
    } flush_mode_e;

    // rem_zero: nothing left once this cycle's dequeue is applied.
    function automatic flush_mode_e flush_mode(
        input logic flush,
        input logic keep,
        input logic rem_zero,
        input logic enq
    );
        flush_mode_e m;
        unique case (1'b1)
            !flush:                       m = FL_NONE;
            flush & !keep:                m = FL_ALL;
            flush & keep & !rem_zero:     m = FL_KEEP_HEAD;
            flush & keep & rem_zero & enq: m = FL_KEEP_ENQ;
            default:                      m = FL_KEEP_NONE;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/id_inst_buffer_if.sv
// Valid/ready bundle carrying one {pc, inst} pair.
// master drives the payload, slave returns ready.
interface id_inst_buffer_if #(
    parameter int PC_W   = 32,
    parameter int INST_W = 32
);
    logic              valid;
    logic              ready;
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;

    modport master (output valid, output pc, output inst, input ready);
    modport slave  (input valid, input pc, input inst, output ready);
endinterface

// File: rtl/id_buf_ram.sv
// DEPTH x W register array: one write port, one async read port.
// Contents are intentionally left unreset.
module id_buf_ram
    import id_inst_buffer_pkg::*;
#(
    parameter int DEPTH = ID_BUF_DEPTH,
    parameter int W     = IF_TO_ID_WD
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);
    logic [W-1:0] mem [DEPTH];

    // Capture the write on the rising edge.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/id_inst_buffer.sv
// IF-to-ID instruction buffer: circular queue of {pc, inst} pairs
// with valid/ready on both sides and branch flush with delay-slot keep.
module id_inst_buffer
    import id_inst_buffer_pkg::*;
#(
    parameter int DEPTH    = ID_BUF_DEPTH,
    parameter int PC_W     = ID_PC_W,
    parameter int INST_W   = ID_INST_W,
    parameter int AF_LEVEL = DEPTH - 1
) (
    input  logic                       clk,
    input  logic                       rst,
    id_inst_buffer_if.slave            in_if,
    id_inst_buffer_if.master           out_if,
    input  logic                       flush,
    input  logic                       flush_keep_slot,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       stallreq
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int W  = PC_W + INST_W;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [CW-1:0] AF   = CW'(AF_LEVEL);

    logic [AW-1:0] wp, rp, wp_n, rp_n;
    logic [CW-1:0] count_n, rem;
    logic          in_rdy, out_vld, enq, deq, we;
    logic [W-1:0]  rdata;
    flush_mode_e   mode;

    assign in_rdy   = count < FULL;
    assign out_vld  = count != '0;
    assign stallreq = count >= AF;
    assign enq      = in_if.valid & in_rdy;
    assign deq      = out_vld & out_if.ready;
    assign rem      = count - CW'(deq);
    assign mode     = flush_mode(flush, flush_keep_slot, rem == '0, enq);

    // Next pointers/occupancy; flush overrides the normal enqueue.
    always_comb begin
        rp_n    = rp + AW'(deq);
        wp_n    = wp;
        count_n = count;
        we      = 1'b0;
        unique case (mode)
            FL_NONE: begin
                wp_n    = wp + AW'(enq);
                count_n = count + CW'(enq) - CW'(deq);
                we      = enq;
            end
            FL_ALL: begin
                wp_n    = rp_n;
                count_n = '0;
            end
            FL_KEEP_HEAD: begin
                wp_n    = rp_n + AW'(1);
                count_n = CW'(1);
            end
            FL_KEEP_ENQ: begin
                wp_n    = wp + AW'(1);
                count_n = CW'(1);
                we      = 1'b1;
            end
            FL_KEEP_NONE: begin
                wp_n    = rp_n;
                count_n = '0;
            end
            default: begin
                wp_n    = wp;
                count_n = count;
            end
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            wp    <= wp_n;
            rp    <= rp_n;
            count <= count_n;
        end
    end

    id_buf_ram #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wp),
        .wdata ({in_if.pc, in_if.inst}),
        .raddr (rp),
        .rdata (rdata)
    );

    assign in_if.ready  = in_rdy;
    assign out_if.valid = out_vld;
    assign out_if.pc    = out_vld ? rdata[W-1:INST_W] : '0;
    assign out_if.inst  = out_vld ? rdata[INST_W-1:0] : '0;
endmodule

// File: tb/tb_id_inst_buffer.sv
// Self-checking bench for id_inst_buffer: reference queue scoreboard
// plus per-scenario inline checks.
module tb_id_inst_buffer;
    localparam int DEPTH = 4;
    localparam int AF    = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       flush = 1'b0;
    logic       keep = 1'b0;
    logic [2:0] count;
    logic       stallreq;
    int         n_cmp = 0;
    int         n_err = 0;

    logic [63:0] mq[$];

    id_inst_buffer_if #(.PC_W(32), .INST_W(32)) in_if ();
    id_inst_buffer_if #(.PC_W(32), .INST_W(32)) out_if ();

    id_inst_buffer #(
        .DEPTH    (DEPTH),
        .PC_W     (32),
        .INST_W   (32),
        .AF_LEVEL (AF)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .in_if           (in_if),
        .out_if          (out_if),
        .flush           (flush),
        .flush_keep_slot (keep),
        .count           (count),
        .stallreq        (stallreq)
    );

    always #5 clk = ~clk;

    // Scoreboard: compare against the reference queue, then advance it.
    always @(negedge clk) begin : mon
        int sz;
        logic e_enq, e_deq;
        logic [63:0] head;
        if (rst) begin
            mq.delete();
        end else begin
            sz = mq.size();
            n_cmp++;
            if (count !== 3'(sz)) begin
                n_err++;
                $display("FAIL sb_count got %0d want %0d", count, sz);
            end
            n_cmp++;
            if (out_if.valid !== (sz != 0)) begin
                n_err++;
                $display("FAIL sb_out_valid got %b want %b", out_if.valid, sz != 0);
            end
            n_cmp++;
            if (in_if.ready !== (sz < DEPTH)) begin
                n_err++;
                $display("FAIL sb_in_ready got %b want %b", in_if.ready, sz < DEPTH);
            end
            n_cmp++;
            if (stallreq !== (sz >= AF)) begin
                n_err++;
                $display("FAIL sb_stallreq got %b want %b", stallreq, sz >= AF);
            end
            head = (sz != 0) ? mq[0] : 64'h0;
            n_cmp++;
            if ({out_if.pc, out_if.inst} !== head) begin
                n_err++;
                $display("FAIL sb_head got %h/%h want %h/%h",
                         out_if.pc, out_if.inst, head[63:32], head[31:0]);
            end
            e_enq = in_if.valid && (sz < DEPTH);
            e_deq = (sz != 0) && out_if.ready;
            if (e_deq) void'(mq.pop_front());
            if (flush) begin
                if (!keep) begin
                    mq.delete();
                end else if (mq.size() != 0) begin
                    head = mq[0];
                    mq.delete();
                    mq.push_back(head);
                end else if (e_enq) begin
                    mq.push_back({in_if.pc, in_if.inst});
                end
            end else if (e_enq) begin
                mq.push_back({in_if.pc, in_if.inst});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc);
        in_if.valid = 1'b1;
        in_if.pc    = pc;
        in_if.inst  = $urandom;
        step();
        in_if.valid = 1'b0;
    endtask

    task automatic test_reset();
        in_if.valid  = 1'b0;
        in_if.pc     = '0;
        in_if.inst   = '0;
        out_if.ready = 1'b0;
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if (count !== 3'd0) begin
            n_err++; $display("FAIL rst_count got %0d want 0", count);
        end
        n_cmp++;
        if (out_if.valid !== 1'b0) begin
            n_err++; $display("FAIL rst_out_valid got %b want 0", out_if.valid);
        end
        n_cmp++;
        if (out_if.pc !== 32'h0 || out_if.inst !== 32'h0) begin
            n_err++;
            $display("FAIL rst_out_data got %h/%h want 0/0", out_if.pc, out_if.inst);
        end
        n_cmp++;
        if (in_if.ready !== 1'b1) begin
            n_err++; $display("FAIL rst_in_ready got %b want 1", in_if.ready);
        end
        n_cmp++;
        if (stallreq !== 1'b0) begin
            n_err++; $display("FAIL rst_stallreq got %b want 0", stallreq);
        end
        repeat (2) step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_fill_drain();
        out_if.ready = 1'b0;
        for (int i = 0; i < 4; i++) push(32'(i * 4));
        n_cmp++;
        if (count !== 3'd4) begin
            n_err++; $display("FAIL fill_count got %0d want 4", count);
        end
        n_cmp++;
        if (in_if.ready !== 1'b0) begin
            n_err++; $display("FAIL fill_in_ready got %b want 0", in_if.ready);
        end
        n_cmp++;
        if (stallreq !== 1'b1) begin
            n_err++; $display("FAIL fill_stallreq got %b want 1", stallreq);
        end
        // Full buffer refuses input even while the head leaves.
        out_if.ready = 1'b1;
        push(32'h10);
        n_cmp++;
        if (count !== 3'd3) begin
            n_err++; $display("FAIL full_deq_count got %0d want 3", count);
        end
        repeat (3) step();
        n_cmp++;
        if (out_if.valid !== 1'b0) begin
            n_err++; $display("FAIL drain_valid got %b want 0", out_if.valid);
        end
        out_if.ready = 1'b0;
    endtask

    task automatic test_stream();
        logic [31:0] pc;
        pc = 32'h100;
        out_if.ready = 1'b1;
        in_if.valid  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_if.pc   = pc;
            in_if.inst = $urandom;
            step();
            n_cmp++;
            if (count !== 3'd1 || out_if.pc !== pc) begin
                n_err++;
                $display("FAIL stream_%0d got cnt %0d pc %h want cnt 1 pc %h",
                         i, count, out_if.pc, pc);
            end
            pc = pc + 32'd4;
        end
        in_if.valid = 1'b0;
        step();
        n_cmp++;
        if (count !== 3'd0) begin
            n_err++; $display("FAIL stream_end_count got %0d want 0", count);
        end
        out_if.ready = 1'b0;
    endtask

    task automatic flush_setup(input logic k);
        out_if.ready = 1'b0;
        push(32'h10);
        push(32'h14);
        push(32'h18);
        out_if.ready = 1'b1;
        flush        = 1'b1;
        keep         = k;
        push(32'h1C);
        flush        = 1'b0;
        keep         = 1'b0;
        out_if.ready = 1'b0;
    endtask

    task automatic test_flush_no_keep();
        flush_setup(1'b0);
        n_cmp++;
        if (count !== 3'd0 || out_if.valid !== 1'b0) begin
            n_err++;
            $display("FAIL flush_all got cnt %0d vld %b want 0 0", count, out_if.valid);
        end
        step();
    endtask

    task automatic test_flush_keep();
        flush_setup(1'b1);
        n_cmp++;
        if (count !== 3'd1 || out_if.pc !== 32'h14) begin
            n_err++;
            $display("FAIL flush_keep got cnt %0d pc %h want 1 00000014", count, out_if.pc);
        end
        out_if.ready = 1'b1;
        step();
        out_if.ready = 1'b0;
        n_cmp++;
        if (out_if.valid !== 1'b0) begin
            n_err++; $display("FAIL flush_keep_tail got vld %b want 0", out_if.valid);
        end
    endtask

    task automatic test_keep_empty();
        flush       = 1'b1;
        keep        = 1'b1;
        in_if.valid = 1'b1;
        in_if.pc    = 32'h40;
        in_if.inst  = 32'h2402_0001;
        step();
        flush       = 1'b0;
        keep        = 1'b0;
        in_if.valid = 1'b0;
        n_cmp++;
        if (count !== 3'd1 || out_if.pc !== 32'h40 || out_if.inst !== 32'h2402_0001) begin
            n_err++;
            $display("FAIL keep_empty got cnt %0d %h/%h want 1 00000040/24020001",
                     count, out_if.pc, out_if.inst);
        end
        out_if.ready = 1'b1;
        step();
        out_if.ready = 1'b0;
        flush = 1'b1;
        keep  = 1'b1;
        step();
        flush = 1'b0;
        keep  = 1'b0;
        n_cmp++;
        if (count !== 3'd0) begin
            n_err++; $display("FAIL keep_empty_noenq got cnt %0d want 0", count);
        end
    endtask

    task automatic test_async_reset();
        out_if.ready = 1'b0;
        push(32'h80);
        push(32'h84);
        push(32'h88);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        n_cmp++;
        if (out_if.valid !== 1'b0 || count !== 3'd0 || in_if.ready !== 1'b1) begin
            n_err++;
            $display("FAIL async_rst got vld %b cnt %0d rdy %b want 0 0 1",
                     out_if.valid, count, in_if.ready);
        end
        step();
        rst = 1'b0;
        push(32'h200);
        n_cmp++;
        if (count !== 3'd1 || out_if.pc !== 32'h200) begin
            n_err++;
            $display("FAIL post_rst got cnt %0d pc %h want 1 00000200", count, out_if.pc);
        end
        out_if.ready = 1'b1;
        step();
        out_if.ready = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_stream();
        test_flush_no_keep();
        test_flush_keep();
        test_keep_empty();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/id_inst_buffer.md
# id_inst_buffer

Parametrised instruction buffer between IF and the decode stage. It captures each fetched `{pc, inst}` pair in a DEPTH-entry circular queue and presents the oldest entry to decode through a valid/ready handshake. Decode stalls therefore no longer lose the instruction-SRAM read data. A branch-resolved flush discards wrong-path entries and can preserve the delay-slot instruction.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, at least 2
- PC_W, 32, PC width
- INST_W, 32, instruction width
- AF_LEVEL, DEPTH-1, occupancy at or above which `stallreq` is raised

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  IF offers an entry this cycle
- in_ready  out  1  buffer can accept; equals `count < DEPTH`
- in_pc  in  PC_W  PC of the offered instruction
- in_inst  in  INST_W  instruction word (SRAM read data aligned with in_pc)
- out_valid  out  1  head entry is valid
- out_ready  in  1  decode consumes the head this cycle
- out_pc  out  PC_W  head PC
- out_inst  out  INST_W  head instruction
- flush  in  1  discard wrong-path entries
- flush_keep_slot  in  1  qualifies flush: preserve one delay-slot entry
- count  out  $clog2(DEPTH+1)  current occupancy
- stallreq  out  1  `count >= AF_LEVEL`; feeds the stall controller

## Operation
- Storage: DEPTH × (PC_W+INST_W) array, write pointer `wp`, read pointer `rp`, occupancy `count`.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally modulo DEPTH.
- Enqueue (`enq`) = `in_valid & in_ready`. It writes to `mem[wp]` and increments `wp`.
- Dequeue (`deq`) = `out_valid & out_ready`. It increments `rp`.
- `count` update:
  - +1 on enq only
  - −1 on deq only
  - unchanged on both or neither
- `out_valid` = `count != 0`. `out_pc` and `out_inst` = `mem[rp]`; they are don't-care when `out_valid` is 0 and are driven 0 in that case.
- `in_ready` depends only on `count`, never on `out_ready`. A full buffer does not accept input even if the head is dequeued in the same cycle.
- Flush is evaluated after this cycle's deq. Let R = entries remaining after deq, excluding this cycle's enq.
  - flush=1, keep=0: all R entries and any same-cycle enq are dropped. Next state: `count` = 0, `wp` = `rp`.
  - flush=1, keep=1, R≥1: the oldest remaining entry is kept; all others and any same-cycle enq are dropped. Next state: `count` = 1, `wp` = `rp_next+1`.
  - flush=1, keep=1, R=0: a same-cycle enq is kept as the slot (`count` = 1). With no enq, `count` = 0 and nothing pending is recorded; the in-flight slot is accepted normally later.
- `flush_keep_slot` is ignored when `flush` = 0.
- Behaviour for `in_valid` with `in_ready` = 0: the input is ignored, and IF must hold it.

## Timing
- Reset (async, takes effect immediately):
  - `wp` = `rp` = `count` = 0
  - `out_valid` = 0, `out_pc` = 0, `out_inst` = 0
  - `in_ready` = 1, `stallreq` = 0
  - memory contents are not reset
- Latency: an entry enqueued in cycle N is visible on `out_*` in cycle N+1. There is no combinational in→out bypass.
- Dequeue takes effect at the edge. The next head is presented the following cycle.
- Throughput is one entry per cycle sustained with DEPTH ≥ 2.
- `flush` takes priority over a same-cycle enq, except for the keep-slot R=0 case.
- Reset asserted mid-operation drops all entries. Outputs go to their reset values without waiting for a clock edge.
- `stallreq` and `in_ready` are registered-state functions. They have no combinational path from any input.

## Structure
- `ID_BUF_DEPTH` and the `{pc, inst}` entry width (`IF_TO_ID_WD`-compatible) belong as constants in `lib/defines.vh`.
- One sub-module is natural: `id_buf_ram`, a DEPTH×W register array with one write port and one asynchronous read port.
- Pointer, count and flush logic stay in `id_inst_buffer`.

## Test plan
- Fill and drain:
  - Enqueue pc 0x00, 0x04, 0x08, 0x0C with `out_ready` = 0. Required: `count` = 4, `in_ready` = 0, `stallreq` = 1 (AF_LEVEL = 3).
  - Then assert `out_ready`. Required: outputs in order 0x00, 0x04, 0x08, 0x0C, then `out_valid` = 0.
- Streaming: continuous `in_valid` with `out_ready` = 1 for 20 cycles. Required: one entry out per cycle, `count` stays at 1, PCs are contiguous across pointer wrap-around.
- Flush, no keep: 3 entries held (0x10, 0x14, 0x18), head dequeued, `flush` = 1, keep = 0, enq 0x1C in the same cycle. Required: next cycle `count` = 0, `out_valid` = 0.
- Flush with keep: same setup with keep = 1. Required: `count` = 1, `out_pc` = 0x14; 0x18 and 0x1C are never output.
- Keep with empty buffer: `flush` = 1, keep = 1, `count` = 0, same-cycle enq 0x40/0x24020001. Required: next cycle `out_pc` = 0x40, `out_inst` = 0x24020001.
- Async reset: assert `rst` mid-cycle with 3 entries held. Required: `out_valid` drops before the next edge, `count` = 0, `in_ready` = 1.
